// File: rtl/adc_query_arbiter.sv
// adc_query_arbiter: round-robin sharing of the ADC controller UART link among NREQ requesters.
// Sends 0xA1+chan, collects a 2-byte little-endian reply or times out, and returns it to the grantee.
module adc_query_arbiter #(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [2*NREQ-1:0] req_chan,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [15:0]       rsp_data,
   output logic              rsp_timeout,
   output logic [7:0]        tx_tdata,
   output logic              tx_tvalid,
   input  logic              tx_tready,
   input  logic [7:0]        rx_tdata,
   input  logic              rx_tvalid,
   output logic              rx_tready
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, DONE} state_t;

   state_t          r_state, w_next;
   logic [IW-1:0]   r_rr_ptr, r_grant, w_gnt, w_low, w_high;
   logic [1:0]      r_chan, w_chan;
   logic [TW-1:0]   r_timer;
   logic [7:0]      r_lo, r_hi;
   logic            r_to, w_any, w_hit, w_wait, w_expire;

   // Prefer the lowest valid index at or above rr_ptr, else wrap to the lowest valid index.
   always_comb begin
      w_low  = '0;
      w_high = '0;
      w_hit  = 1'b0;
      w_chan = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) w_low = IW'(i);
         if (req_valid[i] && IW'(i) >= r_rr_ptr) begin
            w_hit  = 1'b1;
            w_high = IW'(i);
         end
      end
      w_gnt = w_hit ? w_high : w_low;
      for (int i = 0; i < NREQ; i++)
         if (IW'(i) == w_gnt) w_chan = req_chan[2*i +: 2];
   end

   assign w_any    = |req_valid;
   assign w_wait   = (r_state == WAIT_LO) || (r_state == WAIT_HI);
   assign w_expire = (r_timer == TMAX) && !rx_tvalid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? SEND : IDLE;
         SEND:    w_next = tx_tready ? WAIT_LO : SEND;
         WAIT_LO: w_next = rx_tvalid ? WAIT_HI : (w_expire ? DONE : WAIT_LO);
         WAIT_HI: w_next = (rx_tvalid || w_expire) ? DONE : WAIT_HI;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_chan   <= '0;
         r_timer  <= '0;
         r_lo     <= '0;
         r_hi     <= '0;
         r_to     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_any) begin
            r_grant <= w_gnt;
            r_chan  <= w_chan;
            r_to    <= 1'b0;
         end
         // Timer saturates at its terminal value instead of wrapping.
         if (r_state == SEND && tx_tready) r_timer <= '0;
         else if (w_wait && r_timer != TMAX) r_timer <= r_timer + TW'(1);
         if (w_wait && rx_tvalid) begin
            if (r_state == WAIT_LO) r_lo <= rx_tdata;
            else r_hi <= rx_tdata;
         end else if (w_wait && w_expire) begin
            r_lo <= '0;
            r_hi <= '0;
            r_to <= 1'b1;
         end
         if (r_state == DONE) r_rr_ptr <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);
      end
   end

   assign req_ready   = (r_state == IDLE && w_any) ? NREQ'(1) << w_gnt : '0;
   assign rsp_valid   = (r_state == DONE) ? NREQ'(1) << r_grant : '0;
   assign rsp_data    = (r_state == DONE) ? {r_hi, r_lo} : 16'h0000;
   assign rsp_timeout = (r_state == DONE) && r_to;
   assign tx_tvalid   = (r_state == SEND);
   assign tx_tdata    = tx_tvalid ? 8'hA1 + {6'b0, r_chan} : 8'h00;
   assign rx_tready   = 1'b1;
endmodule

// File: tb/tb_adc_query_arbiter.sv
// tb_adc_query_arbiter: scenario tasks with a response scoreboard for adc_query_arbiter.
module tb_adc_query_arbiter;
   localparam int NREQ = 4;
   localparam int TO   = 16;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  req_valid = '0, req_ready, rsp_valid;
   logic [7:0]  req_chan = '0, tx_tdata, rx_tdata = '0;
   logic [15:0] rsp_data;
   logic        rsp_timeout, tx_tvalid, tx_tready = 1'b1, rx_tvalid = 1'b0, rx_tready;

   typedef struct packed {logic [3:0] v; logic [15:0] d; logic t;} rsp_t;
   rsp_t sb[$];
   int n_chk = 0, n_pass = 0, cyc = 0;

   adc_query_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_chan(req_chan),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
      .tx_tready(tx_tready), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
      .rx_tready(rx_tready));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_ready(output logic [3:0] g, output int c, output bit ok);
      ok = 0; g = '0; c = 0;
      #1;
      for (int i = 0; i < 64 && !ok; i++) begin
         if ((req_ready & req_valid) != 0) begin ok = 1; g = req_ready; c = cyc; end
         else @(negedge clk);
      end
   endtask

   task automatic wait_tx(output logic [7:0] b, output int c, output bit ok);
      ok = 0; b = '0; c = 0;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (tx_tvalid && tx_tready) begin ok = 1; b = tx_tdata; c = cyc; end
         else @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output rsp_t r, output int c, output bit ok);
      ok = 0; r = '0; c = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (rsp_valid != 0) begin ok = 1; r = {rsp_valid, rsp_data, rsp_timeout}; c = cyc; end
         else @(negedge clk);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_tvalid = 1'b1; rx_tdata = b;
      @(negedge clk);
      rx_tvalid = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0; req_valid = '0; rx_tvalid = 1'b0; tx_tready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({req_ready, rsp_valid, rsp_data, rsp_timeout, tx_tvalid, tx_tdata, rx_tready} !== {33'd0, 1'b1})
         $display("FAIL reset_outputs got rdy=%b rv=%b d=%h to=%b tv=%b td=%h rr=%b", req_ready, rsp_valid, rsp_data, rsp_timeout, tx_tvalid, tx_tdata, rx_tready);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (req_ready !== 4'b0 || tx_tvalid !== 1'b0) $display("FAIL idle_quiet got rdy=%b tv=%b exp 0", req_ready, tx_tvalid);
      else n_pass++;
   endtask

   task automatic test_single;
      logic [3:0] g; logic [7:0] b; rsp_t r, e; int ca, ch, c; bit ok;
      req_chan = 8'b00_00_00_10; req_valid = 4'b0001;
      wait_ready(g, ca, ok);
      n_chk++;
      if (!ok || g !== 4'b0001) $display("FAIL single_grant got=%b exp=0001 ok=%0d", g, ok); else n_pass++;
      @(negedge clk); req_valid = '0;
      n_chk++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hA3) $display("FAIL single_tx got tv=%b td=%h exp 1/a3", tx_tvalid, tx_tdata); else n_pass++;
      wait_tx(b, ch, ok);
      @(negedge clk);
      n_chk++;
      if (tx_tvalid !== 1'b0) $display("FAIL single_tx_once got tv=%b exp 0", tx_tvalid); else n_pass++;
      sb.push_back({4'b0001, 16'h1234, 1'b0});
      send_rx(8'h34); send_rx(8'h12);
      wait_rsp(r, c, ok); e = sb.pop_front();
      n_chk++;
      if (!ok || r !== e) $display("FAIL single_rsp got=%h exp=%h ok=%0d", r, e, ok); else n_pass++;
      n_chk++;
      if (c - ca !== 4) $display("FAIL single_latency got=%0d exp=4", c - ca); else n_pass++;
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 4'b0) $display("FAIL single_pulse got rv=%b exp 0000", rsp_valid); else n_pass++;
   endtask

   task automatic test_round_robin;
      logic [3:0] g, ge; logic [7:0] b, be; rsp_t r, e; int c, ch; bit ok;
      do_reset;
      req_chan = 8'b11_10_01_00; req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         ge = 4'(1 << (k % 4)); be = 8'(8'hA1 + k % 4);
         wait_ready(g, c, ok);
         n_chk++;
         if (!ok || g !== ge) $display("FAIL rr_grant%0d got=%b exp=%b", k, g, ge); else n_pass++;
         @(negedge clk);
         wait_tx(b, ch, ok);
         n_chk++;
         if (!ok || b !== be) $display("FAIL rr_tx%0d got=%h exp=%h", k, b, be); else n_pass++;
         @(negedge clk);
         sb.push_back({ge, 8'(8'h10 + k), 8'(8'hC0 + k), 1'b0});
         send_rx(8'(8'hC0 + k)); send_rx(8'(8'h10 + k));
         wait_rsp(r, c, ok); e = sb.pop_front();
         n_chk++;
         if (!ok || r !== e) $display("FAIL rr_rsp%0d got=%h exp=%h", k, r, e); else n_pass++;
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure;
      logic [3:0] g; logic [7:0] b; rsp_t r, e; int c, ch, bad; bit ok;
      @(negedge clk);
      tx_tready = 1'b0; req_chan = 8'b00_01_00_00; req_valid = 4'b0100;
      wait_ready(g, c, ok);
      n_chk++;
      if (!ok || g !== 4'b0100) $display("FAIL bp_grant got=%b exp=0100", g); else n_pass++;
      @(negedge clk); req_valid = '0; req_chan = 8'hFF;
      bad = 0;
      repeat (20) begin
         if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hA2 || rsp_valid !== 4'b0) bad++;
         @(negedge clk);
      end
      n_chk++;
      if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else n_pass++;
      tx_tready = 1'b1;
      wait_tx(b, ch, ok);
      n_chk++;
      if (!ok || b !== 8'hA2) $display("FAIL bp_tx got=%h exp=a2", b); else n_pass++;
      repeat (6) @(negedge clk);
      sb.push_back({4'b0100, 16'h5AA5, 1'b0});
      send_rx(8'hA5); send_rx(8'h5A);
      wait_rsp(r, c, ok); e = sb.pop_front();
      n_chk++;
      if (!ok || r !== e) $display("FAIL bp_rsp got=%h exp=%h", r, e); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      logic [3:0] g; logic [7:0] b; rsp_t r, e; int c, ch; bit ok;
      req_chan = 8'b00_00_11_00; req_valid = 4'b0010;
      wait_ready(g, c, ok);
      n_chk++;
      if (!ok || g !== 4'b0010) $display("FAIL to_grant got=%b exp=0010", g); else n_pass++;
      @(negedge clk); req_valid = '0;
      wait_tx(b, ch, ok);
      n_chk++;
      if (!ok || b !== 8'hA4) $display("FAIL to_tx got=%h exp=a4", b); else n_pass++;
      @(negedge clk);
      sb.push_back({4'b0010, 16'h0000, 1'b1});
      send_rx(8'h55);
      wait_rsp(r, c, ok); e = sb.pop_front();
      n_chk++;
      if (!ok || r !== e) $display("FAIL to_rsp got=%h exp=%h", r, e); else n_pass++;
      n_chk++;
      if (c - ch !== TO + 1) $display("FAIL to_latency got=%0d exp=%0d", c - ch, TO + 1); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_race;
      logic [3:0] g; logic [7:0] b; rsp_t r, e; int c, ch; bit ok;
      req_chan = 8'h00; req_valid = 4'b1000;
      wait_ready(g, c, ok);
      n_chk++;
      if (!ok || g !== 4'b1000) $display("FAIL race_grant got=%b exp=1000", g); else n_pass++;
      @(negedge clk); req_valid = '0;
      wait_tx(b, ch, ok);
      n_chk++;
      if (!ok || b !== 8'hA1) $display("FAIL race_tx got=%h exp=a1", b); else n_pass++;
      @(negedge clk);
      send_rx(8'h66);
      for (int i = 0; i < 40 && cyc < ch + TO; i++) @(negedge clk);
      sb.push_back({4'b1000, 16'h8866, 1'b0});
      send_rx(8'h88);
      wait_rsp(r, c, ok); e = sb.pop_front();
      n_chk++;
      if (!ok || r !== e) $display("FAIL race_rsp got=%h exp=%h", r, e); else n_pass++;
      n_chk++;
      if (c - ch !== TO + 1) $display("FAIL race_latency got=%0d exp=%0d", c - ch, TO + 1); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_stray;
      logic [3:0] g; logic [7:0] b; rsp_t r, e; int c, ch, bad; bit ok;
      send_rx(8'h77);
      bad = 0;
      repeat (4) begin
         if (rsp_valid !== 4'b0 || tx_tvalid !== 1'b0) bad++;
         @(negedge clk);
      end
      n_chk++;
      if (bad !== 0) $display("FAIL stray_idle got %0d active cycles exp 0", bad); else n_pass++;
      req_chan = 8'b00_00_00_01; req_valid = 4'b0001;
      wait_ready(g, c, ok);
      n_chk++;
      if (!ok || g !== 4'b0001) $display("FAIL stray_grant got=%b exp=0001", g); else n_pass++;
      @(negedge clk); req_valid = '0;
      wait_tx(b, ch, ok);
      n_chk++;
      if (!ok || b !== 8'hA2) $display("FAIL stray_tx got=%h exp=a2", b); else n_pass++;
      @(negedge clk);
      sb.push_back({4'b0001, 16'hABCD, 1'b0});
      send_rx(8'hCD); send_rx(8'hAB);
      wait_rsp(r, c, ok); e = sb.pop_front();
      n_chk++;
      if (!ok || r !== e) $display("FAIL stray_rsp got=%h exp=%h", r, e); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_wait_hi;
      logic [3:0] g; logic [7:0] b; rsp_t r, e; int c, ch; bit ok, seen;
      req_chan = 8'b00_10_00_00; req_valid = 4'b0100;
      wait_ready(g, c, ok);
      @(negedge clk); req_valid = '0;
      wait_tx(b, ch, ok);
      @(negedge clk);
      send_rx(8'h11);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({req_ready, rsp_valid, rsp_data, rsp_timeout, tx_tvalid, tx_tdata, rx_tready} !== {33'd0, 1'b1})
         $display("FAIL rst_async got rdy=%b rv=%b d=%h to=%b tv=%b td=%h", req_ready, rsp_valid, rsp_data, rsp_timeout, tx_tvalid, tx_tdata);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_rx(8'h99);
      seen = 0;
      repeat (6) begin
         if (rsp_valid !== 4'b0) seen = 1;
         @(negedge clk);
      end
      n_chk++;
      if (seen) $display("FAIL rst_no_rsp got rsp_valid pulse exp none"); else n_pass++;
      req_chan = 8'b11_10_01_00; req_valid = 4'hF;
      wait_ready(g, c, ok);
      n_chk++;
      if (!ok || g !== 4'b0001) $display("FAIL rst_rr_ptr got=%b exp=0001", g); else n_pass++;
      @(negedge clk); req_valid = '0;
      wait_tx(b, ch, ok);
      n_chk++;
      if (!ok || b !== 8'hA1) $display("FAIL rst_tx got=%h exp=a1", b); else n_pass++;
      @(negedge clk);
      sb.push_back({4'b0001, 16'h0F0E, 1'b0});
      send_rx(8'h0E); send_rx(8'h0F);
      wait_rsp(r, c, ok); e = sb.pop_front();
      n_chk++;
      if (!ok || r !== e) $display("FAIL rst_next_rsp got=%h exp=%h", r, e); else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_backpressure;
      test_timeout;
      test_race;
      test_stray;
      test_reset_wait_hi;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0d cycles", cyc);
      $fatal(1);
   end
endmodule
